// File: rtl/vector_cache_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : vector_cache_pkg
//  Description : Shared types for the vector-cache mesh: read-return payload,
//                transaction id, and the edge collector's channel-index type
//                and FIFO depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package vector_cache_pkg;

    localparam int VC_NUM_CH          = 8;
    localparam int VC_EDGE_FIFO_DEPTH = 4;

    typedef struct packed {
        logic [1:0] direction_id;   // 0=west 1=east 2=south 3=north
        logic [3:0] src_id;
        logic [5:0] tag;
    } txnid_t;

    typedef struct packed {
        txnid_t      txnid;
        logic [31:0] data;
    } data_pld_t;

    typedef logic [$clog2(VC_NUM_CH)-1:0] vc_ch_idx_t;

endpackage
`default_nettype wire

// File: rtl/vc_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : vc_rr_arb
//  Description : Combinational round-robin arbiter. Grants the first
//                requesting channel at or after rr_ptr_i, wrapping around.
//  Revision    : 1.0 - initial release
// ============================================================================
module vc_rr_arb #(
    parameter  int NUM_CH = 8,
    localparam int IW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IW-1:0]     rr_ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [IW-1:0]     gnt_idx_o,
    output logic              gnt_vld_o
);

    int idx;

    // Scan channels starting at the round-robin pointer; first requester wins.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(rr_ptr_i) + k) % NUM_CH;
            if (!gnt_vld_o && req_i[idx]) begin
                gnt_vld_o      = 1'b1;
                gnt_o[idx]     = 1'b1;
                gnt_idx_o      = IW'(idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vc_edge_rdata_collector.sv
`default_nettype none
// ============================================================================
//  Module      : vc_edge_rdata_collector
//  Description : Mesh-edge sink for read-return beats. Every beat is captured
//                into a per-channel FIFO (the mesh cannot be stalled), drained
//                round-robin into one registered valid/ready port, and each
//                freed slot is returned to the issuer as a one-cycle credit.
//  Revision    : 1.0 - initial release
// ============================================================================
module vc_edge_rdata_collector
    import vector_cache_pkg::*;
#(
    parameter  int         NUM_CH = VC_NUM_CH,
    parameter  int         DEPTH  = VC_EDGE_FIFO_DEPTH,
    parameter  logic [1:0] DIR_ID = 2'd0,
    localparam int         IW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int         AW     = $clog2(DEPTH),
    localparam int         CW     = AW + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            data_in_vld,
    input  data_pld_t [NUM_CH-1:0]       data_in,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output data_pld_t                    out_pld,
    output logic [IW-1:0]                out_ch,
    output logic [NUM_CH-1:0]            credit_rtn,
    output logic [NUM_CH-1:0]            err_ovf,
    output logic [NUM_CH-1:0]            err_dir
);

    logic [NUM_CH-1:0] dir_ok;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] ovf_set;
    logic [NUM_CH-1:0] nonempty;
    data_pld_t         head [NUM_CH];

    logic [NUM_CH-1:0] gnt;
    logic [IW-1:0]     gnt_idx;
    logic              gnt_vld;
    logic              load_en;

    logic              out_vld_q;
    data_pld_t         out_pld_q;
    logic [IW-1:0]     out_ch_q;
    logic [IW-1:0]     rr_ptr_q;
    logic [NUM_CH-1:0] pop_q;
    logic [NUM_CH-1:0] credit_rtn_q;
    logic [NUM_CH-1:0] err_ovf_q;
    logic [NUM_CH-1:0] err_dir_q;

    assign load_en = !out_vld_q || out_rdy;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        data_pld_t      mem_q [DEPTH];
        logic [AW-1:0]  wr_ptr_q;
        logic [AW-1:0]  rd_ptr_q;
        logic [CW-1:0]  cnt_q;
        logic [CW-1:0]  cnt_d;
        logic           full;

        assign dir_ok[i]   = (data_in[i].txnid.direction_id == DIR_ID);
        assign full        = (cnt_q == CW'(DEPTH));
        assign nonempty[i] = (cnt_q != '0);
        assign pop[i]      = load_en && gnt[i];
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        assign push[i]     = data_in_vld[i] && dir_ok[i] && (!full || pop[i]);
        assign ovf_set[i]  = data_in_vld[i] && dir_ok[i] && full && !pop[i];
        assign head[i]     = mem_q[rd_ptr_q];

        // Occupancy after this cycle's push and pop.
        always_comb begin
            cnt_d = cnt_q + CW'(push[i]) - CW'(pop[i]);
        end

        // Beat storage; contents are don't-care while the entry is empty.
        always_ff @(posedge clk) begin
            if (push[i]) begin
                mem_q[wr_ptr_q] <= data_in[i];
            end
        end

        // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_q + AW'(push[i]);
                rd_ptr_q <= rd_ptr_q + AW'(pop[i]);
                cnt_q    <= cnt_d;
            end
        end
    end

    vc_rr_arb #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req_i     (nonempty),
        .rr_ptr_i  (rr_ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    // Output register, round-robin pointer, credit pipeline and sticky errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q    <= 1'b0;
            out_pld_q    <= '0;
            out_ch_q     <= '0;
            rr_ptr_q     <= '0;
            pop_q        <= '0;
            credit_rtn_q <= '0;
            err_ovf_q    <= '0;
            err_dir_q    <= '0;
        end else begin
            // The credit is returned the cycle after its beat appears on the output.
            pop_q        <= pop;
            credit_rtn_q <= pop_q;
            err_ovf_q    <= err_ovf_q | ovf_set;
            err_dir_q    <= err_dir_q | (data_in_vld & ~dir_ok);
            if (load_en) begin
                if (gnt_vld) begin
                    out_vld_q <= 1'b1;
                    out_pld_q <= head[gnt_idx];
                    out_ch_q  <= gnt_idx;
                    rr_ptr_q  <= (gnt_idx == IW'(NUM_CH - 1)) ? '0 : gnt_idx + IW'(1);
                end else begin
                    out_vld_q <= 1'b0;
                end
            end
        end
    end

    assign out_vld    = out_vld_q;
    assign out_pld    = out_pld_q;
    assign out_ch     = out_ch_q;
    assign credit_rtn = credit_rtn_q;
    assign err_ovf    = err_ovf_q;
    assign err_dir    = err_dir_q;

`ifndef SYNTHESIS
    // Issuer-side credit view: a beat that arrives while the issuer still held
    // a credit is legal and must never overflow.
    int sim_cred_q [NUM_CH];

    function automatic int sim_cred_next(input int c, input logic take, input logic give);
        int n = c;
        if (take && n > 0) n--;
        if (give && n < DEPTH) n++;
        return n;
    endfunction

    // Track credits held by the issuer for each channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) sim_cred_q[i] <= DEPTH;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                sim_cred_q[i] <= sim_cred_next(sim_cred_q[i], data_in_vld[i] && dir_ok[i], credit_rtn_q[i]);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_sva
        a_no_ovf_legal: assert property (@(posedge clk) disable iff (!rst_n)
            (data_in_vld[i] && dir_ok[i] && sim_cred_q[i] != 0) |-> !ovf_set[i]);
    end

    a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_vld_q && !out_rdy) |=> ($stable(out_pld_q) && $stable(out_ch_q)));
`endif

endmodule
`default_nettype wire
